// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and registers
// fetched words into IF/ID, with delay-slot branch redirects and stall handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {OFF, RUN, PEND} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } ifid_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend, pend_nxt;
  logic [31:0] target;
  logic        hold_pc, hold_id;
  ifid_t       ifid;
  logic [31:0] count;

  // 2'b10 behaves as 2'b11: holding IF/ID implies holding the PC too.
  assign hold_pc = stall_i[0] | stall_i[1];
  assign hold_id = stall_i[1];
  assign target  = {branch_target_i[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      pc    <= RESET_PC;
      pend  <= 32'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      pend  <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend;
    case (state)
      OFF: begin
        state_nxt = RUN;
        pc_nxt    = RESET_PC;
      end
      RUN: begin
        if (!hold_pc) begin
          pc_nxt = branch_flag_i ? target : pc + 32'd4;
        end else if (branch_flag_i) begin
          pend_nxt  = target;
          state_nxt = PEND;
        end
      end
      PEND: begin
        // A fresh redirect supersedes the latched one, even on the release cycle.
        if (branch_flag_i) pend_nxt = target;
        if (!hold_pc) begin
          pc_nxt    = branch_flag_i ? target : pend;
          state_nxt = RUN;
        end
      end
      default: state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid  <= '0;
      count <= 32'h0;
    end else if (state == OFF) begin
      ifid.inst  <= 32'h0;
      ifid.valid <= 1'b0;
    end else if (!hold_id) begin
      if (hold_pc) begin
        ifid.inst  <= 32'h0;
        ifid.valid <= 1'b0;
      end else begin
        ifid  <= '{pc: pc, inst: rom_data_i, valid: 1'b1};
        count <= count + 32'd1;
      end
    end
  end

  assign rom_ce_o      = (state != OFF);
  assign rom_addr_o    = pc;
  assign id_pc_o       = ifid.pc;
  assign id_inst_o     = ifid.inst;
  assign id_valid_o    = ifid.valid;
  assign fetch_count_o = count;

endmodule
